inta_sequencer: RTL and testbench

- CPU-side responder to the PIC's INT/INTA handshake.
- Watches INT, generates the two-pulse INTA sequence and captures the interrupt vector byte driven by the PIC on the second pulse.
- Hands the vector to the CPU core and waits for the service routine to finish before it can acknowledge again.
- Sits between the PIC's control logic (INT, INTA, data bus) and the CPU core model.

---
 rtl/inta_sequencer.sv | 150 +++++++++++++++
 tb/tb_inta_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// inta_sequencer: CPU-side INT/INTA responder, captures the PIC vector byte.
// Optional EOI write after the ISR completes: define INTA_SEQ_EOI_EN.
module inta_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_in,
  input  logic       if_enable,
  input  logic [7:0] data_in,
  input  logic       service_done,
  output logic       inta,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       busy,
  output logic       eoi_wr,
  output logic [7:0] eoi_data
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK1,
    S_GAP,
    S_ACK2,
    S_DELIVER,
    S_SERVICE
`ifdef INTA_SEQ_EOI_EN
    , S_EOI
`endif
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   int_sync;
  logic                   rearm_q;
  logic                   ack2_entry;

  assign int_sync   = sync_q[SYNC_STAGES-1];
  assign ack2_entry = (state_d == S_ACK2) && (state_q != S_ACK2);

  // INT input synchroniser chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= int_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Next-state and phase counter decode
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (int_sync && if_enable && rearm_q)
          state_d = S_ACK1;
      end
      S_ACK1: begin
        if (cnt_q == PULSE_LAST) state_d = S_GAP;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_ACK2;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_ACK2: begin
        if (cnt_q == PULSE_LAST) state_d = S_DELIVER;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_DELIVER: begin
        state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (service_done) begin
`ifdef INTA_SEQ_EOI_EN
          state_d = S_EOI;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef INTA_SEQ_EOI_EN
      S_EOI: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, rearm guard and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rearm_q      <= 1'b1;
      inta         <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      if (!int_sync)
        rearm_q <= 1'b1;
      else if (ack2_entry)
        rearm_q <= 1'b0;
      inta         <= (state_d == S_ACK1) ||
                      (state_d == S_ACK2);
      vector_valid <= (state_d == S_DELIVER);
      busy         <= (state_d != S_IDLE);
      if ((state_q == S_ACK2) && (state_d == S_DELIVER))
        vector <= data_in;
    end
  end

`ifdef INTA_SEQ_EOI_EN
  // Non-specific EOI write toward the PIC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eoi_wr   <= 1'b0;
      eoi_data <= 8'h00;
    end else begin
      eoi_wr   <= (state_d == S_EOI);
      eoi_data <= (state_d == S_EOI) ? 8'h20 : 8'h00;
    end
  end
`else
  assign eoi_wr   = 1'b0;
  assign eoi_data = 8'h00;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: table, directed and randomized checks of inta_sequencer.
// Build with or without INTA_SEQ_EOI_EN.
module tb_inta_sequencer;

  localparam int P  = 2;
  localparam int G  = 2;
  localparam int S  = 2;
  localparam int P3 = 3;
  localparam int G3 = 1;
`ifdef INTA_SEQ_EOI_EN
  localparam bit EOI_EN = 1'b1;
`else
  localparam bit EOI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rst3;
  logic       int_in;
  logic       if_enable;
  logic [7:0] data_in;
  logic       service_done;

  logic       inta, vector_valid, busy, eoi_wr;
  logic [7:0] vector, eoi_data;
  logic       inta_3, vector_valid_3, busy_3, eoi_wr_3;
  logic [7:0] vector_3, eoi_data_3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inta_sequencer #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .int_in      (int_in),
    .if_enable   (if_enable),
    .data_in     (data_in),
    .service_done(service_done),
    .inta        (inta),
    .vector      (vector),
    .vector_valid(vector_valid),
    .busy        (busy),
    .eoi_wr      (eoi_wr),
    .eoi_data    (eoi_data)
  );

  inta_sequencer #(
    .PULSE_CYCLES(P3),
    .GAP_CYCLES  (G3),
    .SYNC_STAGES (S)
  ) dut3 (
    .clk         (clk),
    .reset       (rst3),
    .int_in      (int_in),
    .if_enable   (if_enable),
    .data_in     (data_in),
    .service_done(service_done),
    .inta        (inta_3),
    .vector      (vector_3),
    .vector_valid(vector_valid_3),
    .busy        (busy_3),
    .eoi_wr      (eoi_wr_3),
    .eoi_data    (eoi_data_3)
  );

  typedef struct {
    logic       i_int;
    logic       i_en;
    logic [7:0] i_data;
    logic       i_sd;
    logic       e_inta;
    logic       e_vv;
    logic       e_busy;
    logic [7:0] e_vec;
    logic       e_eoi;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(
    logic a, logic b, logic [7:0] c, logic d,
    logic e, logic f, logic g, logic [7:0] h, logic i);
    vec_t v;
    v.i_int  = a;
    v.i_en   = b;
    v.i_data = c;
    v.i_sd   = d;
    v.e_inta = e;
    v.e_vv   = f;
    v.e_busy = g;
    v.e_vec  = h;
    v.e_eoi  = i;
    return v;
  endfunction

  task automatic chk1(string nm, logic a, logic e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic chk8(string nm, logic [7:0] a, logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk32(string nm, int a, int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic get(int id);
    case (id)
      0:       return inta;
      1:       return vector_valid;
      2:       return busy;
      3:       return inta_3;
      4:       return vector_valid_3;
      5:       return busy_3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(int id, logic val, int lim, string nm);
    int n;
    n = 0;
    while (get(id) !== val && n < lim) begin
      step();
      n++;
    end
    chk1(nm, get(id), val);
  endtask

  task automatic finish_seq(int base, string nm);
    wait_until(base + 1, 1'b1, 30, {nm, "_vv"});
    step();
    service_done = 1'b1;
    step();
    service_done = 1'b0;
    wait_until(base + 2, 1'b0, 10, {nm, "_idle"});
  endtask

  task automatic pattern3(string nm);
    wait_until(3, 1'b1, 12, {nm, "_start"});
    for (int k = 1; k < 2 * P3 + G3; k++) begin
      step();
      chk1($sformatf("%s_pat%0d", nm, k), inta_3,
           (k < P3) || (k >= P3 + G3));
    end
    step();
    chk1({nm, "_vv"}, vector_valid_3, 1'b1);
    chk8({nm, "_vec"}, vector_3, 8'h5A);
  endtask

  task automatic run_random(int cycles);
    bit         q[$];
    bit         rearm, nr, isync;
    int         mode, k;
    logic [7:0] mvec;
    q = {};
    for (int i = 0; i < S; i++) q.push_back(1'b0);
    rearm = 1'b1;
    mode  = 0;
    k     = 0;
    mvec  = 8'h00;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(7) == 0) int_in = ~int_in;
      if_enable    = ($urandom_range(9) != 0);
      data_in      = 8'($urandom);
      service_done = ($urandom_range(3) == 0);
      isync = q[0];
      nr    = rearm;
      if (mode == 1 && k == P + G - 1) nr = 1'b0;
      if (!isync) nr = 1'b1;
      case (mode)
        0: if (isync && if_enable && rearm) begin
             mode = 1;
             k    = 0;
           end
        1: begin
             if (k == 2 * P + G - 1) mvec = data_in;
             if (k == 2 * P + G) begin
               mode = 2;
               k    = 0;
             end else begin
               k++;
             end
           end
        2: if (service_done) mode = EOI_EN ? 3 : 0;
        default: mode = 0;
      endcase
      rearm = nr;
      q.push_back(int_in);
      void'(q.pop_front());
      step();
      chk1("rnd_inta", inta,
           mode == 1 && (k < P || (k >= P + G && k < 2 * P + G)));
      chk1("rnd_vv", vector_valid, mode == 1 && k == 2 * P + G);
      chk1("rnd_busy", busy, mode != 0);
      chk8("rnd_vec", vector, mvec);
      chk1("rnd_eoi", eoi_wr, mode == 3);
      chk8("rnd_eoid", eoi_data, (mode == 3) ? 8'h20 : 8'h00);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int n;

    tbl[0]  = mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    tbl[1]  = mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    tbl[2]  = mk(1, 1, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    tbl[3]  = mk(0, 1, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    tbl[4]  = mk(0, 1, 8'h00, 0, 0, 0, 1, 8'h00, 0);
    tbl[5]  = mk(0, 1, 8'h00, 0, 0, 0, 1, 8'h00, 0);
    tbl[6]  = mk(0, 1, 8'h55, 0, 1, 0, 1, 8'h00, 0);
    tbl[7]  = mk(0, 1, 8'hAA, 0, 1, 0, 1, 8'h00, 0);
    tbl[8]  = mk(0, 1, 8'hAA, 0, 0, 1, 1, 8'hAA, 0);
    tbl[9]  = mk(0, 1, 8'h33, 1, 0, 0, 1, 8'hAA, 0);
    tbl[10] = mk(0, 1, 8'h33, 0, 0, 0, 1, 8'hAA, 0);
    tbl[11] = mk(0, 1, 8'h33, 1, 0, 0, EOI_EN, 8'hAA, EOI_EN);
    tbl[12] = mk(0, 1, 8'h33, 0, 0, 0, 0, 8'hAA, 0);

    reset        = 1'b1;
    rst3         = 1'b1;
    int_in       = 1'b0;
    if_enable    = 1'b0;
    data_in      = 8'h00;
    service_done = 1'b0;
    step();
    step();
    chk1("rst_inta", inta, 1'b0);
    chk1("rst_vv", vector_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_vec", vector, 8'h00);
    chk1("rst_eoi", eoi_wr, 1'b0);
    chk8("rst_eoid", eoi_data, 8'h00);
    chk1("rst3_inta", inta_3, 1'b0);
    chk1("rst3_busy", busy_3, 1'b0);
    chk8("rst3_vec", vector_3, 8'h00);
    reset = 1'b0;

    for (int r = 0; r < 13; r++) begin
      int_in       = tbl[r].i_int;
      if_enable    = tbl[r].i_en;
      data_in      = tbl[r].i_data;
      service_done = tbl[r].i_sd;
      step();
      chk1($sformatf("tbl%0d_inta", r), inta, tbl[r].e_inta);
      chk1($sformatf("tbl%0d_vv", r), vector_valid, tbl[r].e_vv);
      chk1($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      chk8($sformatf("tbl%0d_vec", r), vector, tbl[r].e_vec);
      chk1($sformatf("tbl%0d_eoi", r), eoi_wr, tbl[r].e_eoi);
      chk8($sformatf("tbl%0d_eoid", r), eoi_data,
           tbl[r].e_eoi ? 8'h20 : 8'h00);
    end
    service_done = 1'b0;

    int_in    = 1'b1;
    if_enable = 1'b1;
    finish_seq(0, "stale_first");
    seen = 0;
    repeat (20) begin
      step();
      if (inta) seen++;
    end
    chk32("stale_no_ack", seen, 0);
    int_in = 1'b0;
    step();
    int_in = 1'b1;
    step();
    n = 0;
    while (!inta && n < 10) begin
      step();
      n++;
    end
    chk32("rearm_latency", n, 2);
    finish_seq(0, "rearm");

    int_in = 1'b0;
    repeat (3) step();
    if_enable = 1'b0;
    int_in    = 1'b1;
    seen = 0;
    repeat (20) begin
      step();
      if (inta || busy) seen++;
    end
    chk32("gate_hold", seen, 0);
    if_enable = 1'b1;
    step();
    chk1("gate_latency", inta, 1'b1);
    finish_seq(0, "gate");

    int_in = 1'b0;
    repeat (3) step();
    int_in    = 1'b1;
    if_enable = 1'b1;
    data_in   = 8'h00;
    wait_until(0, 1'b1, 10, "mid_start");
    step();
    step();
    chk1("mid_gap", inta, 1'b0);
    int_in    = 1'b0;
    if_enable = 1'b0;
    data_in   = 8'hAF;
    step();
    step();
    chk1("mid_ack2", inta, 1'b1);
    step();
    step();
    chk1("mid_vv", vector_valid, 1'b1);
    chk8("mid_vec", vector, 8'hAF);
    finish_seq(0, "mid");

    int_in    = 1'b0;
    if_enable = 1'b1;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    run_random(1500);

    service_done = 1'b0;
    int_in       = 1'b0;
    if_enable    = 1'b1;
    data_in      = 8'h5A;
    step();
    rst3 = 1'b0;
    repeat (3) step();
    int_in = 1'b1;
    pattern3("d3a");
    step();
    service_done = 1'b1;
    step();
    service_done = 1'b0;
    wait_until(5, 1'b0, 10, "d3a_idle");
    int_in = 1'b0;
    repeat (3) step();
    int_in = 1'b1;
    wait_until(3, 1'b1, 12, "d3b_start");
    repeat (4) step();
    chk1("d3b_in_ack2", inta_3, 1'b1);
    #2;
    rst3 = 1'b1;
    #1;
    chk1("d3b_async_inta", inta_3, 1'b0);
    chk1("d3b_async_busy", busy_3, 1'b0);
    chk8("d3b_async_vec", vector_3, 8'h00);
    chk1("d3b_async_vv", vector_valid_3, 1'b0);
    @(negedge clk);
    rst3 = 1'b0;
    pattern3("d3c");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
